epp_regfile: RTL and testbench

Parametrised EPP slave for the Digilent parallel port. It replaces hard-coded single-address command decoding with a synchronised, fully handshaked register file. It provides a command-pulse register, NUM_REGS-1 read/write control registers and NUM_STATUS read-only status bytes. It sits between the board EPP pins and game/control logic, such as the tetris input and debug paths.

---
 rtl/epp_regfile_if.sv | 37 +++
 rtl/epp_regfile.sv | 240 ++++++++++++++++++++++++
 tb/tb_epp_regfile.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/epp_regfile_if.sv
// ----------------------------------------------------------------------------
// epp_regfile_if
//   Control/handshake half of the Digilent EPP port. The strobes and the
//   direction line come from the host; EppWait is the slave's reply.
//   The 8-bit data bus is a true tristate pin and is carried as a separate
//   inout port on epp_regfile.
//
//   Signals:
//     EppAstb  host -> slave  address strobe, active low, async to clk
//     EppDstb  host -> slave  data strobe, active low, async to clk
//     EppWR    host -> slave  0 = host write, 1 = host read
//     EppWait  slave -> host  handshake, high while the cycle is held
//
//   Modports:
//     master  host side (drives strobes and EppWR)
//     slave   register-file side (drives EppWait)
// ----------------------------------------------------------------------------
interface epp_regfile_if;
    logic EppAstb;
    logic EppDstb;
    logic EppWR;
    logic EppWait;

    modport master (
        output EppAstb,
        output EppDstb,
        output EppWR,
        input  EppWait
    );

    modport slave (
        input  EppAstb,
        input  EppDstb,
        input  EppWR,
        output EppWait
    );
endinterface

// File: rtl/epp_regfile.sv
// ----------------------------------------------------------------------------
// epp_regfile
//   EPP slave exposing a small register file to the host:
//     0x00                      command register, write pulses cmd_pulse,
//                               reads back 0x00, bit 7 also clears addr_err
//     0x01 .. NUM_REGS-1        read/write control registers
//     0x80 .. 0x80+NUM_STATUS-1 read-only status bytes
//   Any other address is unmapped: writes are dropped, reads return 0xFF and
//   both set the sticky addr_err. Every access completes the handshake.
//
//   Ports:
//     clk        system clock
//     rst        asynchronous, active-high reset
//     epp        EPP strobes/direction in, EppWait out (slave modport)
//     EppDB      bidirectional EPP data bus, driven only during a read hold
//     cmd_pulse  one-clk pulse of the byte written to address 0
//     ctrl_regs  flattened control registers, byte k = address k (byte 0 = 0)
//     status_in  flattened status bytes, byte k = address 0x80+k
//     addr_err   sticky unmapped-access flag
//
//   Optional build macro:
//     EPP_AUTOINC_EN  when defined, the address register increments (mod 256)
//                     after every data cycle for block transfers.
// ----------------------------------------------------------------------------
module epp_regfile #(
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned NUM_STATUS  = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  REG_RESET   = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst,
    epp_regfile_if.slave              epp,
    inout  wire  [7:0]                EppDB,
    output logic [7:0]                cmd_pulse,
    output logic [8*NUM_REGS-1:0]     ctrl_regs,
    input  logic [8*NUM_STATUS-1:0]   status_in,
    output logic                      addr_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    // ------------------------------------------------------------------------
    // Strobe / direction synchronisers. Reset to the idle (high) level so a
    // reset never fabricates a strobe edge.
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] astb_sync_q;
    logic [SYNC_STAGES-1:0] dstb_sync_q;
    logic [SYNC_STAGES-1:0] wr_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            astb_sync_q <= '1;
            dstb_sync_q <= '1;
            wr_sync_q   <= '1;
        end else begin
            astb_sync_q <= {astb_sync_q[SYNC_STAGES-2:0], epp.EppAstb};
            dstb_sync_q <= {dstb_sync_q[SYNC_STAGES-2:0], epp.EppDstb};
            wr_sync_q   <= {wr_sync_q[SYNC_STAGES-2:0], epp.EppWR};
        end
    end

    logic astb_s;
    logic dstb_s;
    logic wr_s;

    assign astb_s = astb_sync_q[SYNC_STAGES-1];
    assign dstb_s = dstb_sync_q[SYNC_STAGES-1];
    assign wr_s   = wr_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0] state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] latch_q, latch_d;
    logic       rd_q, rd_d;          // current cycle is a host read
    logic [7:0] cmd_pulse_q, cmd_pulse_d;
    logic       addr_err_q, addr_err_d;
    logic [7:0] regs_q [1:NUM_REGS-1];
    logic [7:0] regs_d [1:NUM_REGS-1];

    // ------------------------------------------------------------------------
    // Address decode of the current address register
    // ------------------------------------------------------------------------
    logic       is_cmd;
    logic       is_ctrl;
    logic       is_stat;
    logic [7:0] ctrl_val;
    logic [7:0] stat_val;

    always_comb begin
        is_cmd   = (addr_q == 8'h00);
        is_ctrl  = 1'b0;
        is_stat  = 1'b0;
        ctrl_val = 8'h00;
        stat_val = 8'h00;
        for (int k = 1; k < int'(NUM_REGS); k++) begin
            if (addr_q == 8'(k)) begin
                is_ctrl  = 1'b1;
                ctrl_val = regs_q[k];
            end
        end
        for (int k = 0; k < int'(NUM_STATUS); k++) begin
            if (addr_q == 8'(128 + k)) begin
                is_stat  = 1'b1;
                stat_val = status_in[8*k +: 8];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        latch_d     = latch_q;
        rd_d        = rd_q;
        cmd_pulse_d = 8'h00;
        addr_err_d  = addr_err_q;
        regs_d      = regs_q;

        case (state_q)
            ST_IDLE: begin
                if (!astb_s) begin
                    state_d = ST_ADDR;
                end else if (!dstb_s) begin
                    state_d = ST_DATA;
                end
            end

            ST_ADDR: begin
                rd_d = wr_s;
                if (wr_s) begin
                    latch_d = addr_q;
                end else begin
                    addr_d = EppDB;
                end
                state_d = ST_HOLD;
            end

            ST_DATA: begin
                rd_d = wr_s;
                if (wr_s) begin
                    if (is_cmd) begin
                        latch_d = 8'h00;
                    end else if (is_ctrl) begin
                        latch_d = ctrl_val;
                    end else if (is_stat) begin
                        latch_d = stat_val;
                    end else begin
                        latch_d    = 8'hFF;
                        addr_err_d = 1'b1;
                    end
                end else begin
                    if (is_cmd) begin
                        cmd_pulse_d = EppDB;
                        if (EppDB[7]) begin
                            addr_err_d = 1'b0;
                        end
                    end else if (is_ctrl) begin
                        for (int k = 1; k < int'(NUM_REGS); k++) begin
                            if (addr_q == 8'(k)) begin
                                regs_d[k] = EppDB;
                            end
                        end
                    end else begin
                        // Status space is read-only; treated like unmapped.
                        addr_err_d = 1'b1;
                    end
                end
`ifdef EPP_AUTOINC_EN
                addr_d = addr_q + 8'd1;
`else
                addr_d = addr_q;
`endif
                state_d = ST_HOLD;
            end

            ST_HOLD: begin
                if (astb_s && dstb_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= 8'h00;
            latch_q     <= 8'h00;
            rd_q        <= 1'b0;
            cmd_pulse_q <= 8'h00;
            addr_err_q  <= 1'b0;
            for (int k = 1; k < int'(NUM_REGS); k++) begin
                regs_q[k] <= REG_RESET;
            end
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            latch_q     <= latch_d;
            rd_q        <= rd_d;
            cmd_pulse_q <= cmd_pulse_d;
            addr_err_q  <= addr_err_d;
            for (int k = 1; k < int'(NUM_REGS); k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign epp.EppWait = (state_q == ST_HOLD);

    // Raw EppWR gates the driver so the bus is released as soon as the host
    // turns it around, without waiting for the synchroniser.
    assign EppDB = ((state_q == ST_HOLD) && rd_q && epp.EppWR) ? latch_q : 8'bz;

    assign cmd_pulse = cmd_pulse_q;
    assign addr_err  = addr_err_q;

    always_comb begin
        ctrl_regs = '0;
        for (int k = 1; k < int'(NUM_REGS); k++) begin
            ctrl_regs[8*k +: 8] = regs_q[k];
        end
    end

endmodule

// File: tb/tb_epp_regfile.sv
// ----------------------------------------------------------------------------
// tb_epp_regfile
//   Directed bench for epp_regfile: host-side EPP cycles with hand-computed
//   expectations for the register map, command pulses, status reads, unmapped
//   accesses, reset mid-cycle and block writes. A pullup on the data bus makes
//   a released bus read as 0xFF.
// ----------------------------------------------------------------------------
module tb_epp_regfile;

    localparam int unsigned NumRegs    = 8;
    localparam int unsigned NumStatus  = 4;
    localparam int unsigned SyncStages = 2;
    localparam logic [7:0]  RegReset   = 8'h5A;
    localparam int          MaxLat     = SyncStages + 2;
    localparam logic [63:0] CtrlReset  = {{7{RegReset}}, 8'h00};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    epp_regfile_if epp_bus ();

    logic        host_oe = 1'b0;
    logic [7:0]  host_db = 8'h00;
    wire  [7:0]  epp_db;
    assign epp_db = host_oe ? host_db : 8'bz;
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (epp_db[i]);
    end

    logic [7:0]  cmd_pulse;
    logic [63:0] ctrl_regs;
    logic [31:0] status_in;
    logic        addr_err;

    epp_regfile #(
        .NUM_REGS    (NumRegs),
        .NUM_STATUS  (NumStatus),
        .SYNC_STAGES (SyncStages),
        .REG_RESET   (RegReset)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .epp       (epp_bus),
        .EppDB     (epp_db),
        .cmd_pulse (cmd_pulse),
        .ctrl_regs (ctrl_regs),
        .status_in (status_in),
        .addr_err  (addr_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Count clocks on which each cmd_pulse bit is high.
    logic cnt_clr = 1'b1;
    int   cnt0    = 0;
    int   cnt7    = 0;
    int   cnt_mid = 0;
    always @(negedge clk) begin
        if (cnt_clr) begin
            cnt0    <= 0;
            cnt7    <= 0;
            cnt_mid <= 0;
        end else begin
            if (cmd_pulse[0])      cnt0    <= cnt0 + 1;
            if (cmd_pulse[7])      cnt7    <= cnt7 + 1;
            if (|cmd_pulse[6:1])   cnt_mid <= cnt_mid + 1;
        end
    end

    // Bounded wait for EppWait to reach lvl; latency must be within MaxLat.
    task automatic wait_handshake(input logic lvl, input string tag);
        int n = 0;
        while (epp_bus.EppWait !== lvl && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 64'(n <= MaxLat), 64'd1);
    endtask

    task automatic epp_cycle(input bit is_addr, input bit is_read, input logic [7:0] wdata,
                             input int hold, input string tag, output logic [7:0] rdata);
        @(negedge clk);
        epp_bus.EppWR = is_read;
        host_db       = wdata;
        host_oe       = !is_read;
        @(negedge clk);
        if (is_addr) epp_bus.EppAstb = 1'b0;
        else         epp_bus.EppDstb = 1'b0;
        wait_handshake(1'b1, {tag, " wait rise"});
        repeat (hold) @(negedge clk);
        rdata = epp_db;
        epp_bus.EppAstb = 1'b1;
        epp_bus.EppDstb = 1'b1;
        wait_handshake(1'b0, {tag, " wait fall"});
        host_oe       = 1'b0;
        epp_bus.EppWR = 1'b1;
    endtask

    logic [63:0] exp_ctrl;
    logic [7:0]  rd;

    initial begin
        epp_bus.EppAstb = 1'b1;
        epp_bus.EppDstb = 1'b1;
        epp_bus.EppWR   = 1'b1;
        status_in       = 32'h11225C33;
        exp_ctrl        = CtrlReset;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst wait", 64'(epp_bus.EppWait), 64'd0);
        check_eq("rst bus released", 64'(epp_db), 64'hFF);
        check_eq("rst cmd_pulse", 64'(cmd_pulse), 64'd0);
        check_eq("rst ctrl_regs", ctrl_regs, exp_ctrl);
        check_eq("rst addr_err", 64'(addr_err), 64'd0);
        rst = 1'b0;
        cnt_clr = 1'b0;
        repeat (2) @(negedge clk);

        // Address write/read and control register write
        epp_cycle(1'b1, 1'b0, 8'h03, 0, "aw 03", rd);
        epp_cycle(1'b1, 1'b1, 8'h00, 0, "ar", rd);
        check_eq("addr readback", 64'(rd), 64'h03);
        epp_cycle(1'b0, 1'b0, 8'hA5, 0, "dw A5", rd);
        exp_ctrl[31:24] = 8'hA5;
        check_eq("ctrl after A5", ctrl_regs, exp_ctrl);
        check_eq("no err after A5", 64'(addr_err), 64'd0);
        epp_cycle(1'b1, 1'b0, 8'h03, 0, "aw 03b", rd);
        epp_cycle(1'b0, 1'b1, 8'h00, 0, "dr 03", rd);
        check_eq("read reg3", 64'(rd), 64'hA5);

        // Command register: long strobe still gives one pulse per bit
        cnt_clr = 1'b1;
        repeat (2) @(negedge clk);
        cnt_clr = 1'b0;
        epp_cycle(1'b1, 1'b0, 8'h00, 0, "aw 00", rd);
        epp_cycle(1'b0, 1'b0, 8'h81, 50, "dw 81", rd);
        repeat (3) @(negedge clk);
        check_eq("cmd bit0 pulses", 64'(cnt0), 64'd1);
        check_eq("cmd bit7 pulses", 64'(cnt7), 64'd1);
        check_eq("cmd other pulses", 64'(cnt_mid), 64'd0);
        check_eq("ctrl after cmd", ctrl_regs, exp_ctrl);
        check_eq("cmd_pulse idle", 64'(cmd_pulse), 64'd0);
        epp_cycle(1'b1, 1'b0, 8'h00, 0, "aw 00b", rd);
        epp_cycle(1'b0, 1'b1, 8'h00, 0, "dr 00", rd);
        check_eq("read cmd reg", 64'(rd), 64'h00);

        // Status reads
        epp_cycle(1'b1, 1'b0, 8'h81, 0, "aw 81", rd);
        epp_cycle(1'b0, 1'b1, 8'h00, 0, "dr 81", rd);
        check_eq("status byte1", 64'(rd), 64'h5C);
        check_eq("bus released after read", 64'(epp_db), 64'hFF);
        epp_cycle(1'b1, 1'b0, 8'h83, 0, "aw 83", rd);
        epp_cycle(1'b0, 1'b1, 8'h00, 0, "dr 83", rd);
        check_eq("status byte3", 64'(rd), 64'h11);
        check_eq("no err after status", 64'(addr_err), 64'd0);

        // Unmapped access and clear
        epp_cycle(1'b1, 1'b0, 8'h40, 0, "aw 40", rd);
        epp_cycle(1'b0, 1'b0, 8'h11, 0, "dw 11 unmapped", rd);
        check_eq("err after unmapped wr", 64'(addr_err), 64'd1);
        check_eq("ctrl after unmapped wr", ctrl_regs, exp_ctrl);
        epp_cycle(1'b0, 1'b1, 8'h00, 0, "dr unmapped", rd);
        check_eq("unmapped read", 64'(rd), 64'hFF);
        epp_cycle(1'b1, 1'b0, 8'h00, 0, "aw 00c", rd);
        epp_cycle(1'b0, 1'b0, 8'h80, 0, "dw 80", rd);
        check_eq("err cleared", 64'(addr_err), 64'd0);
        epp_cycle(1'b1, 1'b0, 8'h82, 0, "aw 82", rd);
        epp_cycle(1'b0, 1'b0, 8'h99, 0, "dw status", rd);
        check_eq("err on status write", 64'(addr_err), 64'd1);
        epp_cycle(1'b1, 1'b0, 8'h00, 0, "aw 00d", rd);
        epp_cycle(1'b0, 1'b0, 8'h01, 0, "dw 01", rd);
        check_eq("err kept without bit7", 64'(addr_err), 64'd1);

        // Reset while holding a read
        epp_cycle(1'b1, 1'b0, 8'h03, 0, "aw 03c", rd);
        @(negedge clk);
        epp_bus.EppWR = 1'b1;
        @(negedge clk);
        epp_bus.EppDstb = 1'b0;
        wait_handshake(1'b1, "rst-read wait rise");
        check_eq("hold drives bus", 64'(epp_db), 64'hA5);
        rst = 1'b1;
        #1;
        check_eq("rst wait drop", 64'(epp_bus.EppWait), 64'd0);
        check_eq("rst bus release", 64'(epp_db), 64'hFF);
        exp_ctrl = CtrlReset;
        check_eq("rst ctrl_regs mid", ctrl_regs, exp_ctrl);
        check_eq("rst addr_err mid", 64'(addr_err), 64'd0);
        @(negedge clk);
        epp_bus.EppDstb = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        epp_cycle(1'b1, 1'b0, 8'h02, 0, "aw 02", rd);
        epp_cycle(1'b0, 1'b0, 8'h77, 0, "dw 77", rd);
        exp_ctrl[23:16] = 8'h77;
        check_eq("ctrl after reset", ctrl_regs, exp_ctrl);

        // Block write
        epp_cycle(1'b1, 1'b0, 8'h01, 0, "aw 01", rd);
        epp_cycle(1'b0, 1'b0, 8'h10, 0, "dw 10", rd);
        epp_cycle(1'b0, 1'b0, 8'h20, 0, "dw 20", rd);
        epp_cycle(1'b0, 1'b0, 8'h30, 0, "dw 30", rd);
`ifdef EPP_AUTOINC_EN
        exp_ctrl[15:8]  = 8'h10;
        exp_ctrl[23:16] = 8'h20;
        exp_ctrl[31:24] = 8'h30;
`else
        exp_ctrl[15:8]  = 8'h30;
`endif
        check_eq("block write", ctrl_regs, exp_ctrl);
        check_eq("final addr_err", 64'(addr_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
